// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and line constants for the UART transmit path.
// The parity state is only reachable when uart_tx is built with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(
        input logic [UART_DATA_BITS-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO in front of the UART serialiser.
// Head entry is visible on rdata without a read strobe.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter, LSB first, idle high.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 100,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] wdata,
    input  logic       wvalid,
    output logic       wready,
    output logic       txd,
    output logic       busy
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t  state_q;
    tx_state_t  state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       txd_q;
    logic       txd_d;
    logic       pop;
    logic       push;
    logic       bit_end;
    logic       last_bit;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_full;

`ifdef UART_TX_PARITY_EN
    logic par_q;
`endif

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign wready   = !fifo_full;
    assign push     = wvalid && wready;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign txd      = txd_q;
    assign bit_end  = (cnt_q == CNT_LAST);
    assign last_bit = (bit_idx_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = START;
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
`ifdef UART_TX_PARITY_EN
                if (bit_end && last_bit) state_d = PARITY;
`else
                if (bit_end && last_bit) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Back-to-back frames: chain straight into the next start bit
                if (bit_end) state_d = fifo_empty ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d = UART_IDLE_LEVEL;
        pop   = 1'b0;
        unique case (state_q)
            IDLE:    pop   = !fifo_empty;
            START:   txd_d = ~UART_IDLE_LEVEL;
            DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            STOP:    pop   = bit_end && !fifo_empty;
            default: txd_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= UART_IDLE_LEVEL;
        end else begin
            txd_q <= txd_d;
            if (state_q == IDLE || bit_end) cnt_q <= '0;
            else                            cnt_q <= cnt_q + CW'(1);
            if (pop)
                shift_q <= fifo_rdata;
            else if (state_q == DATA && bit_end)
                shift_q <= shift_q >> 1;
            if (state_q == START)
                bit_idx_q <= '0;
            else if (state_q == DATA && bit_end)
                bit_idx_q <= bit_idx_q + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn)    par_q <= 1'b0;
        else if (pop) par_q <= even_parity(fifo_rdata);
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a serial receiver model.
// Build with UART_TX_PARITY_EN to exercise the 8E1 frame format.
module tb_uart_tx;

    localparam int CPH   = 4;
    localparam int E     = 2 * CPH;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wvalid = 1'b0;
    logic       wready;
    logic       txd;
    logic       busy;

    logic [7:0] sb [$];
    int         start_q [$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rx_cnt = 0;
    int         n_sent = 0;
    logic       mon_en = 1'b1;

    uart_tx #(
        .CLK_PER_HALF_BIT(CPH),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .txd    (txd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n;
        n = 0;
        wdata  = d;
        wvalid = 1'b1;
        while (!wready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", wready, 1);
        sb.push_back(d);
        n_sent++;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
        repeat (E) @(negedge clk);
    endtask

    // Receiver model: samples mid-bit, pops the scoreboard per frame
    initial begin : rx_mon
        logic       prev;
        logic [7:0] b;
        logic [7:0] exp;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rstn && prev && !txd) begin
                start_q.push_back(cyc);
                repeat (E/2 - 1) @(negedge clk);
                chk("rx_start", txd, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (E) @(negedge clk);
                    b[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (E) @(negedge clk);
                chk("rx_parity", txd, ^b);
`endif
                repeat (E) @(negedge clk);
                chk("rx_stop", txd, 1);
                chk("rx_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("rx_data", b, exp);
                end
                rx_cnt++;
            end
            prev = txd;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d;
        logic       exp_txd;
        int         slot;
        int         idx;
        int         stall;
        int         acc_before;
        int         guard;

        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wready", wready, 1);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame, cycle-exact waveform and busy timing
        d = 8'h55;
        push_byte(d);
        for (int i = 0; i <= E * NSLOT + 1; i++) begin
            if (i < 2) begin
                exp_txd = 1'b1;
            end else begin
                slot = (i - 2) / E;
                if (slot == 0)      exp_txd = 1'b0;
                else if (slot <= 8) exp_txd = d[slot-1];
                else if (slot == 9 && NSLOT == 11) exp_txd = ^d;
                else                exp_txd = 1'b1;
            end
            chk($sformatf("wave_txd_%0d", i), txd, exp_txd);
            if (i == 0)             chk("wave_busy_first", busy, 1);
            if (i == E * NSLOT)     chk("wave_busy_last", busy, 1);
            if (i == E * NSLOT + 1) chk("wave_busy_drop", busy, 0);
            if (i < E * NSLOT + 1) @(negedge clk);
        end
        wait_idle();
        chk("single_sb_empty", sb.size(), 0);

        // Back-to-back frames, no idle gap
        start_q.delete();
        push_byte(8'hA3);
        push_byte(8'h0F);
        push_byte(8'hFF);
        wait_idle();
        chk("b2b_frames", start_q.size(), 3);
        for (int i = 1; i < start_q.size(); i++)
            chk("b2b_pitch", start_q[i] - start_q[i-1], E * NSLOT);
        chk("b2b_sb_empty", sb.size(), 0);

        // Six bytes with wvalid held: fill, stall, push-while-full at pop
        idx        = 0;
        stall      = 0;
        acc_before = -1;
        guard      = 0;
        wdata      = 8'h10;
        wvalid     = 1'b1;
        while (idx < 6 && guard < 3000) begin
            guard++;
            if (wready) begin
                sb.push_back(wdata);
                n_sent++;
                idx++;
                @(negedge clk);
                if (idx < 6) wdata = 8'h10 + 8'(idx);
                else         wvalid = 1'b0;
            end else begin
                if (acc_before < 0) acc_before = idx;
                stall++;
                @(negedge clk);
            end
        end
        wvalid = 1'b0;
        chk("fifo_accepts_before_full", acc_before, 5);
        chk("fifo_stall_cycles", stall, E * NSLOT - 3);
        chk("fifo_all_accepted", idx, 6);
        wait_idle();
        chk("fifo_sb_empty", sb.size(), 0);

        // Reset mid-frame during data bit 3 with two bytes still queued
        mon_en = 1'b0;
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        repeat (33) @(negedge clk);
        chk("prerst_busy", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_wready", wready, 1);
        rstn = 1'b1;
        n_sent = n_sent - sb.size();
        sb.delete();
        repeat (2 * E * NSLOT) @(negedge clk);
        chk("postrst_busy", busy, 0);
        chk("postrst_txd", txd, 1);
        mon_en = 1'b1;
        idx = rx_cnt;
        push_byte(8'h3C);
        wait_idle();
        chk("postrst_one_frame", rx_cnt - idx, 1);
        chk("postrst_sb_empty", sb.size(), 0);

        // Parity patterns (odd and even weight)
        start_q.delete();
        push_byte(8'h07);
        push_byte(8'h03);
        wait_idle();
        chk("par_frames", start_q.size(), 2);
        for (int i = 1; i < start_q.size(); i++)
            chk("par_pitch", start_q[i] - start_q[i-1], E * NSLOT);

        chk("final_sb_empty", sb.size(), 0);
        chk("final_rx_count", rx_cnt, n_sent);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter for the host link: 8N1 frames, LSB first, line idle high.
- Bytes from the core enter a small internal FIFO through a valid/ready handshake. They are serialised on txd at 2*CLK_PER_HALF_BIT clock cycles per bit.
- Sits between the core's output/IO unit and the board TX pin. It mirrors the timing of the receive path.

Parameters:
- CLK_PER_HALF_BIT, 100: half bit period in clk cycles. Bit period E = 2*CLK_PER_HALF_BIT. Must be >= 2.
- FIFO_DEPTH, 4: byte FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- wdata  input  8  byte to send
- wvalid  input  1  wdata valid
- wready  output  1  FIFO can accept a byte (= ~full); a transfer occurs when wvalid && wready at posedge
- txd  output  1  serial line, registered
- busy  output  1  high while a frame is in progress or the FIFO is non-empty

Behaviour:
- Reset (rstn=0 at posedge):
  - txd=1, busy=0, FIFO empty (wready=1 from the next cycle), state IDLE, bit counter and cycle counter 0.
  - Reset mid-frame aborts the frame immediately: txd returns to 1 on the following cycle and queued bytes are discarded.
- FIFO:
  - Count width clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
  - Push when wvalid&&wready.
  - Pop only by the FSM on frame start.
  - Push and pop in the same cycle are allowed when non-empty and non-full; the count is unchanged.
  - Push while full is ignored (wready=0), so no overwrite.
  - wready and busy are combinational from registered state only (no wvalid path).
- FSM states: IDLE, START, DATA, STOP (PARITY when the option is enabled).
  - IDLE: txd=1. If FIFO non-empty: pop the head into an 8-bit shift register, clear the cycle counter, go to START. txd=0 from the next cycle.
  - START: txd=0 for exactly E cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] for E cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: txd=1 for exactly E cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap; frame pitch exactly 10*E cycles);
    - otherwise go to IDLE.
- Latency: byte accepted at cycle N into an empty FIFO while IDLE: pop at N+1, txd falls at N+2.
- Cycle counter: 0..E-1; the end-of-bit event fires at count E-1.
- busy drops in the cycle after the last STOP cycle when the FIFO is empty.
- txd holds its value between transitions (no glitches); registered output only.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Frames are 8E1: a PARITY state of E cycles is inserted between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity), computed at pop time and stored in a register.
  - Frame pitch becomes 11*E cycles.
- Undefined: no PARITY state and no parity logic; 8N1 as above.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam UART_DATA_BITS = 8;
  - localparam UART_IDLE_LEVEL = 1'b1.
- One sub-module, uart_tx_fifo (parameter DEPTH, width 8):
  - ports clk, rstn, push, wdata, pop, rdata, empty, full;
  - rdata shows the head combinationally.
- The FSM, counters and shift register stay in uart_tx.

Test Plan:
- CLK_PER_HALF_BIT=4 (E=8). Push 0x55 when idle -> txd falls 2 cycles after acceptance; then 0 for 8 cycles, bits 1,0,1,0,1,0,1,0 for 8 cycles each, 1 for 8 cycles; busy falls the cycle after.
- Push 0xA3, 0x0F, 0xFF back-to-back -> three frames with no idle gap, pitch exactly 80 cycles. A receiver model decodes 0xA3, 0x0F, 0xFF.
- FIFO_DEPTH=4, push 6 bytes with wvalid held:
  - first byte pops immediately, so wready drops after 5 accepts;
  - wready reasserts after the next frame starts;
  - all bytes arrive in order, none lost or duplicated.
- Assert rstn=0 during DATA bit 3 with 2 bytes queued -> txd=1 next cycle, busy=0, wready=1. A new push afterwards transmits only the new byte.
- Push while full on the same cycle as the STOP-end pop -> push rejected (wready=0 that cycle); the count drops by 1.
- With UART_TX_PARITY_EN, send 0x07 and 0x03 -> parity bits 1 and 0 respectively, pitch 88 cycles at E=8.
